// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch and data-memory wait
// handling, with a saturating stall-cycle counter and a sticky memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic [4:0]           id_rs1_i,
  input  logic [4:0]           id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic                 idex_MemtoReg_i,
  input  logic                 idex_RegWrite_i,
  input  logic [4:0]           idex_WriteReg_i,
  input  logic                 exmem_Branch_i,
  input  logic                 exmem_zero_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  output logic                 pc_enable_o,
  output logic                 ifid_enable_o,
  output logic                 idex_enable_o,
  output logic                 exmem_enable_o,
  output logic                 memwb_enable_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic                 exmem_flush_o,
  output logic                 memwb_flush_o,
  output logic                 pc_src_o,
  output logic [1:0]           ctrl_state_o,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic                 mem_timeout_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_e;

  localparam int            WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TMO = WCW'(MEM_TIMEOUT);

  state_e               state_q, state_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic mem_stall, branch_taken, load_use;

  assign mem_stall    = dmem_req_i & ~dmem_ready_i;
  assign branch_taken = exmem_Branch_i & exmem_zero_i;
  assign load_use     = idex_MemtoReg_i & idex_RegWrite_i & (idex_WriteReg_i != 5'd0) &
                        ((id_use_rs1_i & (id_rs1_i == idex_WriteReg_i)) |
                         (id_use_rs2_i & (id_rs2_i == idex_WriteReg_i)));

  // Outputs are a zero-latency function of state and inputs; reset forces every stage flushed.
  always_comb begin
    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    pc_enable_o    = 1'b1;
    ifid_enable_o  = 1'b1;
    idex_enable_o  = 1'b1;
    exmem_enable_o = 1'b1;
    memwb_enable_o = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_flush_o  = 1'b0;
    memwb_flush_o  = 1'b0;
    pc_src_o       = 1'b0;
    if (!reset_ni) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_enable_o  = 1'b0;
      exmem_enable_o = 1'b0;
      memwb_enable_o = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
      exmem_flush_o  = 1'b1;
      memwb_flush_o  = 1'b1;
    end else if (mem_stall) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_enable_o  = 1'b0;
      exmem_enable_o = 1'b0;
      memwb_enable_o = 1'b0;
      memwb_flush_o  = 1'b1;
    end else if (branch_taken) begin
      pc_src_o      = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (load_use) begin
      pc_enable_o   = 1'b0;
      ifid_enable_o = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  always_comb begin
    state_d = mem_stall ? MEM_WAIT : RUN;
    if (state_q != MEM_WAIT)  wait_cnt_d = '0;
    else if (wait_cnt_q == TMO) wait_cnt_d = TMO;
    else                      wait_cnt_d = wait_cnt_q + 1'b1;
    mem_timeout_d  = mem_timeout_q | (wait_cnt_d == TMO);
    stall_cycles_d = stall_cycles_q;
    if (!pc_enable_o && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ctrl_state_o   = state_q;
  assign stall_cycles_o = stall_cycles_q;
  assign mem_timeout_o  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios, a per-cycle reference model
// built on stall-episode lengths, and literal spot checks of key values.
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, idex_wr;
  logic id_use_rs1, id_use_rs2, idex_m2r, idex_rw, br, zero, req, ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl, pc_src;
  logic [1:0] state;
  logic [CW-1:0] stalls;
  logic timeout;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .idex_MemtoReg_i(idex_m2r), .idex_RegWrite_i(idex_rw), .idex_WriteReg_i(idex_wr),
    .exmem_Branch_i(br), .exmem_zero_i(zero), .dmem_req_i(req), .dmem_ready_i(ready),
    .pc_enable_o(pc_en), .ifid_enable_o(ifid_en), .idex_enable_o(idex_en),
    .exmem_enable_o(exmem_en), .memwb_enable_o(memwb_en),
    .ifid_flush_o(ifid_fl), .idex_flush_o(idex_fl), .exmem_flush_o(exmem_fl),
    .memwb_flush_o(memwb_fl), .pc_src_o(pc_src), .ctrl_state_o(state),
    .stall_cycles_o(stalls), .mem_timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: episode-based view of memory stalls rather than an explicit FSM.
  int run_len = 0;   // consecutive mem-stall cycles ending with the previous cycle
  bit m_to    = 1'b0;
  int m_stall = 0;

  always @(negedge clk) begin
    logic [9:0] exp_v;
    logic       ms, bt, lu;
    if (!rst_n) begin
      exp_v   = 10'b00000_1111_0;
      run_len = 0;
      m_to    = 1'b0;
      m_stall = 0;
      check("m_outs_rst", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                           ifid_fl, idex_fl, exmem_fl, memwb_fl, pc_src}, 32'(exp_v));
      check("m_state_rst", 32'(state), 32'd0);
    end else begin
      ms = req & ~ready;
      bt = br & zero;
      lu = idex_m2r & idex_rw & (idex_wr != 0) &
           ((id_use_rs1 & (id_rs1 == idex_wr)) | (id_use_rs2 & (id_rs2 == idex_wr)));
      if (ms)      exp_v = 10'b00000_0001_0;
      else if (bt) exp_v = 10'b11111_1110_1;
      else if (lu) exp_v = 10'b00111_0100_0;
      else         exp_v = 10'b11111_0000_0;
      check("m_outs", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_fl, idex_fl, exmem_fl, memwb_fl, pc_src}, 32'(exp_v));
      check("m_state", 32'(state), (run_len > 0) ? 32'd1 : 32'd0);
      check("m_stalls", 32'(stalls), 32'(m_stall));
      check("m_timeout", 32'(timeout), 32'(m_to));
      // MEM_WAIT cycles in this episode, counting the current one, equal run_len.
      if (run_len >= TMO) m_to = 1'b1;
      run_len = ms ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
      if (!exp_v[9] && m_stall < CNT_MAX) m_stall++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    idex_m2r = 1'b0; idex_rw = 1'b0; idex_wr = 5'd0;
    br = 1'b0; zero = 1'b0; req = 1'b0; ready = 1'b0;
  endtask

  task automatic load_x5();
    idex_m2r = 1'b1; idex_rw = 1'b1; idex_wr = 5'd5;
  endtask

  initial begin
    clear();
    #3;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_memwb_fl", 32'(memwb_fl), 32'd1);
    check("rst_ifid_fl", 32'(ifid_fl), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load-use on rs2
    load_x5(); id_rs2 = 5'd5; id_use_rs2 = 1'b1; id_rs1 = 5'd1; id_use_rs1 = 1'b1;
    #1;
    check("lu_pc_en", 32'(pc_en), 32'd0);
    check("lu_ifid_en", 32'(ifid_en), 32'd0);
    check("lu_idex_fl", 32'(idex_fl), 32'd1);
    check("lu_exmem_en", 32'(exmem_en), 32'd1);
    tick(); clear(); #1;
    check("lu_stalls", 32'(stalls), 32'd1);
    check("lu_release", 32'(pc_en), 32'd1);
    tick();

    // rd = x0: no hazard
    idex_m2r = 1'b1; idex_rw = 1'b1; idex_wr = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #1;
    check("x0_pc_en", 32'(pc_en), 32'd1);
    check("x0_idex_fl", 32'(idex_fl), 32'd0);
    tick(); clear();

    // rs2 matches but is not read
    load_x5(); id_rs2 = 5'd5; id_use_rs2 = 1'b0; id_rs1 = 5'd1; id_use_rs1 = 1'b1;
    #1;
    check("nouse_pc_en", 32'(pc_en), 32'd1);
    tick();

    // Load-use on rs1
    id_rs1 = 5'd5;
    #1;
    check("lu1_pc_en", 32'(pc_en), 32'd0);
    tick(); clear(); #1;
    check("lu1_stalls", 32'(stalls), 32'd2);
    tick();

    // Taken / not-taken branch
    br = 1'b1; zero = 1'b1;
    #1;
    check("br_pc_src", 32'(pc_src), 32'd1);
    check("br_flushes", 32'({ifid_fl, idex_fl, exmem_fl, memwb_fl}), 32'b1110);
    check("br_pc_en", 32'(pc_en), 32'd1);
    tick();
    zero = 1'b0;
    #1;
    check("nt_pc_src", 32'(pc_src), 32'd0);
    check("nt_flushes", 32'({ifid_fl, idex_fl, exmem_fl, memwb_fl}), 32'b0000);
    tick();

    // Branch wins over load-use
    zero = 1'b1; load_x5(); id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    check("brlu_pc_en", 32'(pc_en), 32'd1);
    check("brlu_pc_src", 32'(pc_src), 32'd1);
    tick(); clear();

    // Memory wait, ready low for 3 cycles
    req = 1'b1; ready = 1'b0;
    #1;
    check("mw_memwb_fl", 32'(memwb_fl), 32'd1);
    check("mw_enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
    check("mw_state0", 32'(state), 32'd0);
    tick();
    check("mw_state1", 32'(state), 32'd1);
    tick(); tick();
    ready = 1'b1;
    #1;
    check("mw_rel_state", 32'(state), 32'd1);
    check("mw_rel_pc_en", 32'(pc_en), 32'd1);
    check("mw_rel_memwb_fl", 32'(memwb_fl), 32'd0);
    check("mw_stalls", 32'(stalls), 32'd5);
    tick(); clear(); #1;
    check("mw_back_run", 32'(state), 32'd0);
    check("mw_no_timeout", 32'(timeout), 32'd0);
    tick();

    // Taken branch held behind a stalled store
    br = 1'b1; zero = 1'b1; req = 1'b1; ready = 1'b0;
    #1;
    check("bs_no_redirect", 32'(pc_src), 32'd0);
    check("bs_ifid_fl", 32'(ifid_fl), 32'd0);
    tick(); tick();
    ready = 1'b1;
    #1;
    check("bs_redirect", 32'(pc_src), 32'd1);
    check("bs_stalls", 32'(stalls), 32'd7);
    tick(); clear();

    // Request withdrawn during MEM_WAIT
    req = 1'b1; ready = 1'b0;
    tick();
    req = 1'b0;
    #1;
    check("rq_state", 32'(state), 32'd1);
    check("rq_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("rq_run", 32'(state), 32'd0);
    check("rq_stalls", 32'(stalls), 32'd8);

    // Timeout with ready never arriving, then counter saturation
    req = 1'b1; ready = 1'b0;
    repeat (4) tick();
    check("to_not_yet", 32'(timeout), 32'd0);
    tick();
    check("to_set", 32'(timeout), 32'd1);
    check("to_stalls", 32'(stalls), 32'd13);
    check("to_still_stall", 32'(pc_en), 32'd0);
    repeat (5) tick();
    check("sat_stalls", 32'(stalls), 32'(CNT_MAX));
    check("sat_timeout", 32'(timeout), 32'd1);

    // Reset mid-wait
    rst_n = 1'b0;
    #1;
    check("rw_state", 32'(state), 32'd0);
    check("rw_timeout", 32'(timeout), 32'd0);
    check("rw_stalls", 32'(stalls), 32'd0);
    check("rw_pc_en", 32'(pc_en), 32'd0);
    check("rw_exmem_fl", 32'(exmem_fl), 32'd1);
    tick();
    rst_n = 1'b1; clear();
    tick(); tick();
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_pc_en", 32'(pc_en), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
